// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD timer: state encoding, digit width,
// and the preset digit clamp.
package bcd_timer_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/bcd_timer_n_digit_step.sv
// One BCD digit of the ripple incrementer/decrementer: steps by one when a
// carry (up) or borrow (down) arrives and passes it on at the 9/0 boundary.
module bcd_digit_step
    import bcd_timer_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    input  logic             i_up,
    input  logic             i_cin,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_cout
);

    always_comb begin
        o_digit = i_digit;
        o_cout  = 1'b0;
        if (i_cin) begin
            if (i_up) begin
                if (i_digit >= 4'd9) begin
                    o_digit = '0;
                    o_cout  = 1'b1;
                end else begin
                    o_digit = i_digit + 4'd1;
                end
            end else begin
                if (i_digit == 4'd0) begin
                    o_digit = 4'd9;
                    o_cout  = 1'b1;
                end else begin
                    o_digit = i_digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_timer_n.sv
// N-digit BCD up/down timer with prescaler, pause/resume, stop or auto-reload
// at the terminal value. All outputs come straight from flops.
module bcd_timer_n
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_start,
    input  logic                  i_pause,
    input  logic                  i_dir,
    input  logic                  i_reload_en,
    input  logic [4*DIGITS-1:0]   i_preset,
    output logic [4*DIGITS-1:0]   o_count_bcd,
    output logic                  o_running,
    output logic                  o_tick,
    output logic                  o_done
);

    localparam int CW = BCD_W * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [CW-1:0]   r_preset, w_preset_nxt;
    logic            r_dir, w_dir_nxt;
    logic [PW-1:0]   r_pre, w_pre_nxt;
    logic            r_chk, w_chk_nxt;
    logic            r_tick, w_tick_nxt;
    logic            r_done, w_done_nxt;
    logic            r_running;

    logic [CW-1:0]   w_clamped;
    logic [CW-1:0]   w_start_ld;
    logic [CW-1:0]   w_start_lat;
    logic [CW-1:0]   w_term;
    logic [CW-1:0]   w_stepped;
    logic [CW-1:0]   w_adv;
    logic [DIGITS:0] w_carry;
    logic            w_wrap;

    always_comb begin
        w_clamped = '0;
        for (int d = 0; d < DIGITS; d++)
            w_clamped[d*BCD_W +: BCD_W] = clamp_digit(i_preset[d*BCD_W +: BCD_W]);
    end

    assign w_start_ld  = i_dir ? '0 : w_clamped;
    assign w_start_lat = r_dir ? '0 : r_preset;
    assign w_term      = r_dir ? r_preset : '0;
    assign w_wrap      = (r_pre == PRE_LAST);

    assign w_carry[0] = 1'b1;
    for (genvar g = 0; g < DIGITS; g++) begin : g_step
        bcd_digit_step u_step (
            .i_digit (r_count[g*BCD_W +: BCD_W]),
            .i_up    (r_dir),
            .i_cin   (w_carry[g]),
            .o_digit (w_stepped[g*BCD_W +: BCD_W]),
            .o_cout  (w_carry[g+1])
        );
    end

    // Sitting on the terminal value (reload mode) or a carry out of the top
    // digit both mean the next tick restarts from the start value.
    assign w_adv = ((r_count == w_term) || w_carry[DIGITS]) ? w_start_lat : w_stepped;

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_preset_nxt = r_preset;
        w_dir_nxt    = r_dir;
        w_pre_nxt    = r_pre;
        w_chk_nxt    = 1'b0;
        w_tick_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        if (i_load) begin
            w_state_nxt  = ST_IDLE;
            w_count_nxt  = w_start_ld;
            w_preset_nxt = w_clamped;
            w_dir_nxt    = i_dir;
            w_pre_nxt    = '0;
        end else if (i_start && r_state != ST_RUN) begin
            w_state_nxt = ST_RUN;
            if (r_state == ST_DONE) begin
                w_count_nxt  = w_start_ld;
                w_preset_nxt = w_clamped;
                w_dir_nxt    = i_dir;
                w_pre_nxt    = '0;
                w_chk_nxt    = 1'b1;
            end else if (r_state == ST_IDLE) begin
                w_chk_nxt = 1'b1;
            end
        end else if (i_pause && r_state == ST_RUN) begin
            w_state_nxt = ST_PAUSE;
        end else if (r_state == ST_RUN) begin
            // A fresh run that already starts on the terminal value ends at once.
            if (r_chk && r_count == w_term) begin
                w_state_nxt = ST_DONE;
                w_done_nxt  = 1'b1;
                w_pre_nxt   = '0;
            end else begin
                w_pre_nxt = w_wrap ? '0 : r_pre + 1'b1;
                if (w_wrap) begin
                    w_tick_nxt  = 1'b1;
                    w_count_nxt = w_adv;
                    if (w_adv == w_term) begin
                        w_done_nxt = 1'b1;
                        if (!i_reload_en) w_state_nxt = ST_DONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_preset  <= '0;
            r_dir     <= 1'b0;
            r_pre     <= '0;
            r_chk     <= 1'b0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_preset  <= w_preset_nxt;
            r_dir     <= w_dir_nxt;
            r_pre     <= w_pre_nxt;
            r_chk     <= w_chk_nxt;
            r_tick    <= w_tick_nxt;
            r_done    <= w_done_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    assign o_count_bcd = r_count;
    assign o_running   = r_running;
    assign o_tick      = r_tick;
    assign o_done      = r_done;

endmodule
